// File: rtl/instr_prefetch_queue_if.sv
// instr_prefetch_queue_if: fetch bus, redirect and core-facing instruction stream of the prefetch queue
interface instr_prefetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  modport master (
    output mem_req, mem_addr, instr_valid, instr, instr_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  mem_req, mem_addr, instr_valid, instr, instr_pc,
    output mem_gnt, mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: in-order instruction prefetcher with credit-limited FIFO and redirect flush
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clock,
  input logic reset_,
  instr_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {FETCH, FLUSH} state_t;
  state_t        state, state_nxt;
  logic [CW-1:0] count, outstanding, drop_cnt, out_nxt;
  logic [CW:0]   inflight;
  logic [31:0]   fetch_pc, resp_pc, target;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic          accept, rsp, drop, push, pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction
  assign inflight        = {1'b0, count} + {1'b0, outstanding};
  assign target          = {bus.redirect_pc[31:2], 2'b00};
  // Credits cover both buffered and in-flight words, so a push can never meet a full FIFO
  assign bus.mem_req     = reset_ && state == FETCH && !bus.redirect && inflight < (CW+1)'(DEPTH);
  assign bus.mem_addr    = fetch_pc;
  assign bus.instr_valid = count != '0;
  assign bus.instr       = bus.instr_valid ? data_mem[rd_ptr] : '0;
  assign bus.instr_pc    = bus.instr_valid ? pc_mem[rd_ptr] : '0;
  always_comb begin
    accept    = bus.mem_req & bus.mem_gnt;
    rsp       = bus.mem_rvalid & (outstanding != '0);
    drop      = rsp & (drop_cnt != '0);
    push      = rsp & !drop & !bus.redirect;
    pop       = bus.instr_valid & bus.instr_ready & !bus.redirect;
    out_nxt   = outstanding + CW'(accept) - CW'(rsp);
    state_nxt = bus.redirect ? (out_nxt != '0 ? FLUSH : FETCH)
              : (state == FLUSH && drop && drop_cnt == CW'(1)) ? FETCH : state;
  end
  always_ff @(posedge clock or negedge reset_)
    if (!reset_) state <= FETCH;
    else state <= state_nxt;
  always_ff @(posedge clock or negedge reset_)
    if (!reset_) begin
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      outstanding <= out_nxt;
      if (bus.redirect) begin
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        fetch_pc <= target;
        resp_pc  <= target;
        drop_cnt <= out_nxt;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (push) begin
          wr_ptr  <= inc(wr_ptr);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) rd_ptr <= inc(rd_ptr);
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (drop) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  always_ff @(posedge clock)
    if (push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      data_mem[wr_ptr] <= bus.mem_rdata;
    end
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: directed checks of fetch, backpressure, redirect flush, wrap and reset
module tb_instr_prefetch_queue;
  logic clock = 1'b0;
  logic reset_;
  int   total = 0;
  int   passed = 0;
  instr_prefetch_queue_if bus();
  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (.clock(clock), .reset_(reset_), .bus(bus));
  always #5 clock = ~clock;
  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction
  task automatic set(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                     input logic rdr, input logic [31:0] rpc);
    bus.mem_gnt     = g;
    bus.mem_rvalid  = rv;
    bus.mem_rdata   = rd;
    bus.instr_ready = rdy;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
    #1;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic do_reset();
    reset_ = 1'b0;
    set(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    reset_ = 1'b1;
  endtask
  initial begin
    // 1: reset values, then streaming fetch with 1-cycle memory
    reset_ = 1'b0;
    set(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    check("rst_req", bus.mem_req, 0);
    check("rst_valid", bus.instr_valid, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_instr", bus.instr, 0);
    check("rst_pc", bus.instr_pc, 0);
    reset_ = 1'b1;
    set(1, 0, 0, 1, 0, 0);
    check("t1_req0", bus.mem_req, 1);
    check("t1_addr0", bus.mem_addr, 32'h0);
    tick();
    set(1, 1, w(0), 1, 0, 0);
    check("t1_addr4", bus.mem_addr, 32'h4);
    check("t1_novalid", bus.instr_valid, 0);
    tick();
    set(1, 1, w(4), 1, 0, 0);
    check("t1_addr8", bus.mem_addr, 32'h8);
    check("t1_valid", bus.instr_valid, 1);
    check("t1_pc0", bus.instr_pc, 32'h0);
    check("t1_w0", bus.instr, w(0));
    tick();
    set(1, 1, w(8), 1, 0, 0);
    check("t1_addr12", bus.mem_addr, 32'hC);
    check("t1_pc4", bus.instr_pc, 32'h4);
    check("t1_w4", bus.instr, w(4));
    tick();
    set(0, 1, w(12), 1, 0, 0);
    check("t1_pc8", bus.instr_pc, 32'h8);
    check("t1_w8", bus.instr, w(8));
    tick();
    set(0, 0, 0, 1, 0, 0);
    check("t1_pc12", bus.instr_pc, 32'hC);
    tick();
    check("t1_drained", bus.instr_valid, 0);
    // 2: backpressure, credit limit of 4
    do_reset();
    set(1, 0, 0, 0, 0, 0);
    tick();
    set(1, 1, w(0), 0, 0, 0);
    tick();
    set(1, 1, w(4), 0, 0, 0);
    tick();
    set(1, 1, w(8), 0, 0, 0);
    check("t2_req4th", bus.mem_req, 1);
    check("t2_addr12", bus.mem_addr, 32'hC);
    tick();
    set(1, 1, w(12), 0, 0, 0);
    check("t2_credit_stop", bus.mem_req, 0);
    tick();
    set(1, 0, 0, 0, 0, 0);
    check("t2_full_req", bus.mem_req, 0);
    check("t2_count4", 32'(dut.count), 4);
    check("t2_head_pc", bus.instr_pc, 32'h0);
    tick();
    set(1, 0, 0, 1, 0, 0);
    check("t2_still_full", bus.mem_req, 0);
    tick();
    set(1, 0, 0, 0, 0, 0);
    check("t2_req16", bus.mem_req, 1);
    check("t2_addr16", bus.mem_addr, 32'h10);
    check("t2_pc4", bus.instr_pc, 32'h4);
    tick();
    set(0, 0, 0, 0, 0, 0);
    check("t2_one_req", bus.mem_req, 0);
    // 3: redirect with three stale responses
    do_reset();
    repeat (3) begin
      set(1, 0, 0, 0, 0, 0);
      tick();
    end
    check("t3_out3", 32'(dut.outstanding), 3);
    set(0, 0, 0, 0, 1, 32'h40);
    check("t3_redir_req", bus.mem_req, 0);
    tick();
    set(1, 0, 0, 0, 0, 0);
    check("t3_flush_req", bus.mem_req, 0);
    check("t3_drop3", 32'(dut.drop_cnt), 3);
    tick();
    set(1, 1, w(0), 0, 0, 0);
    check("t3_flush_req1", bus.mem_req, 0);
    tick();
    set(1, 1, w(4), 0, 0, 0);
    check("t3_flush_req2", bus.mem_req, 0);
    tick();
    set(1, 1, w(8), 0, 0, 0);
    check("t3_flush_req3", bus.mem_req, 0);
    tick();
    set(1, 0, 0, 0, 0, 0);
    check("t3_req40", bus.mem_req, 1);
    check("t3_addr40", bus.mem_addr, 32'h40);
    check("t3_dropped", bus.instr_valid, 0);
    tick();
    set(0, 1, w(32'h40), 0, 0, 0);
    tick();
    set(0, 0, 0, 0, 0, 0);
    check("t3_pc40", bus.instr_pc, 32'h40);
    check("t3_w40", bus.instr, w(32'h40));
    // 4: misaligned redirect target with nothing outstanding
    set(0, 0, 0, 0, 1, 32'h43);
    tick();
    set(0, 0, 0, 0, 0, 0);
    check("t4_req", bus.mem_req, 1);
    check("t4_addr", bus.mem_addr, 32'h40);
    check("t4_flushed", bus.instr_valid, 0);
    check("t4_state", 32'(dut.state), 0);
    // 5: simultaneous response + pop + grant, then redirect + response
    set(1, 0, 0, 0, 0, 0);
    tick();
    set(1, 1, w(32'h40), 0, 0, 0);
    tick();
    set(1, 1, w(32'h44), 1, 0, 0);
    check("t5_addr48", bus.mem_addr, 32'h48);
    tick();
    check("t5_count", 32'(dut.count), 1);
    check("t5_out", 32'(dut.outstanding), 1);
    check("t5_pc44", bus.instr_pc, 32'h44);
    set(0, 1, w(32'h48), 0, 1, 32'h80);
    tick();
    set(0, 0, 0, 0, 0, 0);
    check("t5_rr_valid", bus.instr_valid, 0);
    check("t5_rr_count", 32'(dut.count), 0);
    check("t5_rr_out", 32'(dut.outstanding), 0);
    check("t5_rr_addr", bus.mem_addr, 32'h80);
    check("t5_rr_req", bus.mem_req, 1);
    // 6: address wrap, then async reset with two outstanding
    set(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    tick();
    set(1, 0, 0, 0, 0, 0);
    check("t6_addr_top", bus.mem_addr, 32'hFFFF_FFFC);
    tick();
    set(1, 0, 0, 0, 0, 0);
    check("t6_wrap", bus.mem_addr, 32'h0);
    tick();
    set(1, 1, w(32'hFFFF_FFFC), 0, 0, 0);
    tick();
    check("t6_out2", 32'(dut.outstanding), 2);
    set(0, 0, 0, 0, 0, 0);
    reset_ = 1'b0;
    #1;
    check("t6_rst_req", bus.mem_req, 0);
    check("t6_rst_valid", bus.instr_valid, 0);
    check("t6_rst_addr", bus.mem_addr, 32'h0);
    check("t6_rst_pc", bus.instr_pc, 32'h0);
    check("t6_rst_instr", bus.instr, 32'h0);
    tick();
    reset_ = 1'b1;
    set(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    tick();
    tick();
    set(0, 0, 0, 0, 0, 0);
    check("t6_late_valid", bus.instr_valid, 0);
    check("t6_late_out", 32'(dut.outstanding), 0);
    check("t6_late_count", 32'(dut.count), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
